// File: rtl/mem_loader_if.sv
// Loader bus: word-input handshake, memory write port and status flags.
interface mem_loader_if;
  localparam int unsigned DW = 4;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 6;

  logic          start_clear;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [CW-1:0] count;
  logic          full;
  logic          busy;

  // Producer/observer side: drives commands and data, watches writes and status.
  modport master (
    output start_clear, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, count, full, busy
  );

  // Loader side.
  modport slave (
    input  start_clear, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, count, full, busy
  );
endinterface

// File: rtl/mem_loader.sv
// Write-side sequencer for a 32x4 memory: ascending fill plus a zero-fill sweep.
module mem_loader (
  input  logic         clk,
  input  logic         reset,
  mem_loader_if.slave  bus
);
  localparam int unsigned DW    = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned CW    = 6;
  localparam int unsigned DEPTH = 32;

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          in_ready_q, in_ready_d;
  logic          full_q, full_d;
  logic          busy_q, busy_d;

  // Next state and registered outputs; the clear sweep walks wr_addr itself.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (bus.start_clear) begin
      state_d   = CLEAR;
      ptr_d     = '0;
      count_d   = '0;
      wr_en_d   = 1'b1;
      wr_addr_d = '0;
      wr_data_d = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.in_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = bus.in_data;
            ptr_d     = ptr_q + AW'(1);
            count_d   = count_q + CW'(1);
            if (ptr_q == LAST_ADDR) begin
              state_d = FULL;
            end
          end
        end
        CLEAR: begin
          if (wr_addr_q == LAST_ADDR) begin
            state_d = LOAD;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_addr_q + AW'(1);
            wr_data_d = '0;
          end
        end
        FULL: begin
        end
        default: begin
          state_d = LOAD;
        end
      endcase
    end

    in_ready_d = (state_d == LOAD);
    full_d     = (state_d == FULL);
    busy_d     = (state_d == CLEAR);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LOAD;
      ptr_q      <= '0;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      in_ready_q <= 1'b1;
      full_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      in_ready_q <= in_ready_d;
      full_q     <= full_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.count    = count_q;
  assign bus.full     = full_q;
  assign bus.busy     = busy_q;
endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset named as follows.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
REQ-002 Input ports SHALL be:
- start_clear  input  1  pulse: zero-fill the whole memory.
- in_valid  input  1  in_data holds a word to store.
- in_data  input  4  word to store.
REQ-003 Output ports SHALL be:
- in_ready  output  1  loader accepts a word this cycle.
- wr_en  output  1  write strobe to the 32x4 memory.
- wr_addr  output  5  write address.
- wr_data  output  4  write data.
- count  output  6  number of words stored since the last clear/reset, range 0..32.
- full  output  1  count == 32.
- busy  output  1  clear sequence in progress.

Function
REQ-004 The block SHALL be the write-side companion of the 32-entry x 4-bit memory, filling addresses 0..31 in ascending order.
REQ-005 The FSM SHALL have exactly three states: LOAD, CLEAR, FULL.
REQ-006 In LOAD, in_ready SHALL be 1; all other states SHALL drive in_ready = 0.
REQ-007 Handshake: a word is accepted on a rising edge where in_valid && in_ready; in_data need not be held after acceptance.
REQ-008 On acceptance, in the next cycle the block SHALL drive wr_en=1, wr_addr=write pointer, wr_data=accepted word (1-cycle latency, registered outputs).
REQ-009 Each acceptance SHALL increment the 5-bit write pointer and count by 1.
REQ-010 Acceptance at pointer 31 SHALL wrap the pointer to 0, set count=32, and move LOAD->FULL.
REQ-011 In FULL, full SHALL be 1, in_valid SHALL be ignored, and no write SHALL occur.
REQ-012 start_clear sampled high in any state SHALL move the FSM to CLEAR on that edge, reset pointer and count to 0, and discard any same-cycle in_valid.
REQ-013 In CLEAR, busy SHALL be 1 and the block SHALL issue 32 consecutive writes, wr_en=1, wr_data=0, wr_addr=0,1,...,31, one per cycle, first write in the cycle after entry.
REQ-014 After the write to address 31, the FSM SHALL return to LOAD with pointer=0, count=0, busy=0.
REQ-015 start_clear re-asserted during CLEAR SHALL restart the sweep from address 0.
REQ-016 wr_en SHALL be 0 in every cycle without an acceptance write (REQ-008) or a clear write (REQ-013).
REQ-017 full SHALL be asserted only in FULL; busy only in CLEAR.
REQ-018 count SHALL never exceed 32 or decrement, except to 0 on clear or reset.

Reset
REQ-019 Asserting reset SHALL immediately, without a clock edge, force state=LOAD, pointer=0, count=0, wr_en=0, wr_addr=0, wr_data=0, full=0, busy=0, in_ready=1.
REQ-020 Reset asserted mid-CLEAR or mid-load SHALL abort the operation; memory contents already written SHALL NOT be reverted.
REQ-021 Reset SHALL take priority over start_clear and in_valid.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset, then in_valid=1 with data 0x1,0x2,0x3 on 3 consecutive cycles -> writes (addr 0,0x1),(1,0x2),(2,0x3) each 1 cycle after acceptance; count=3.
- 32 back-to-back accepts -> last write at addr 31; full=1, in_ready=0, count=32; a 33rd in_valid produces no wr_en.
- From FULL, pulse start_clear -> busy=1 for 32 cycles, writes of 0 to addr 0..31; then in_ready=1, count=0, full=0.
- start_clear and in_valid high in the same cycle in LOAD -> word discarded, clear sweep starts at addr 0.
- Asynchronous reset asserted between edges mid-CLEAR (e.g. at addr 10) -> outputs reach reset values before the next edge; after release the next accepted word is written to addr 0.
- in_valid toggling 1,0,1,0 -> writes only for accepted cycles, addresses contiguous with no gaps.
